// File: rtl/maxpool_2x2.sv
// maxpool_2x2: 2x2 stride-2 max pooling of a raster pixel stream (ports: clk, rst, i_data/i_valid in, o_data/o_valid out)
module maxpool_2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNEL = 8,
  parameter int IN_WIDTH = 512,
  parameter int IN_HEIGHT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_WIDTH*CHANNEL-1:0] i_data,
  input  logic i_valid,
  output logic [DATA_WIDTH*CHANNEL-1:0] o_data,
  output logic o_valid
);
  localparam int PW = DATA_WIDTH*CHANNEL;
  localparam int CW = $clog2(IN_WIDTH);
  localparam int RW = $clog2(IN_HEIGHT);
  localparam logic ROW_EVEN = 1'b0;
  localparam logic ROW_ODD = 1'b1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic phase;
  logic [PW-1:0] h, hmax, rd, vmax;
  logic [PW-1:0] row_buf [IN_WIDTH/2];
  logic beat, col_last, row_last;
  assign beat = i_valid && !rst;
  assign col_last = col == CW'(IN_WIDTH-1);
  assign row_last = row == RW'(IN_HEIGHT-1);
  genvar c;
  for (c = 0; c < CHANNEL; c++) begin : g_ch
    assign hmax[c*DATA_WIDTH +: DATA_WIDTH] =
      $signed(h[c*DATA_WIDTH +: DATA_WIDTH]) > $signed(i_data[c*DATA_WIDTH +: DATA_WIDTH]) ?
      h[c*DATA_WIDTH +: DATA_WIDTH] : i_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign vmax[c*DATA_WIDTH +: DATA_WIDTH] =
      $signed(rd[c*DATA_WIDTH +: DATA_WIDTH]) > $signed(hmax[c*DATA_WIDTH +: DATA_WIDTH]) ?
      rd[c*DATA_WIDTH +: DATA_WIDTH] : hmax[c*DATA_WIDTH +: DATA_WIDTH];
  end
  // Unreset RAM with registered read; rd is loaded on the even-col beat and held across gaps.
  always_ff @(posedge clk) begin
    if (beat && col[0] && phase == ROW_EVEN) row_buf[col[CW-1:1]] <= hmax;
    if (beat && !col[0] && phase == ROW_ODD) rd <= row_buf[col[CW-1:1]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      phase <= ROW_EVEN;
      h <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
    end else begin
      o_valid <= beat && col[0] && phase == ROW_ODD;
      if (beat) begin
        col <= col_last ? '0 : col + CW'(1);
        if (col_last) begin
          row <= row_last ? '0 : row + RW'(1);
          phase <= phase == ROW_EVEN ? ROW_ODD : ROW_EVEN;
        end
        if (!col[0]) h <= i_data;
        if (col[0] && phase == ROW_ODD) o_data <= vmax;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: directed bench for maxpool_2x2 on a 4x4 single-channel and an 8x4 eight-channel instance
module tb_maxpool_2x2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] a_d = '0, a_q;
  logic a_v = 1'b0, a_w = 1'b0, a_wd = 1'b0, a_ov;
  logic [127:0] b_d = '0, b_q;
  logic b_v = 1'b0, b_w = 1'b0, b_wd = 1'b0, b_ov;
  logic [15:0] fa [16];
  logic [127:0] fb [32];
  logic [127:0] qa [$];
  logic [127:0] qb [$];
  int total = 0, bad = 0, na = 0, nb = 0;
  maxpool_2x2 #(.DATA_WIDTH(16), .CHANNEL(1), .IN_WIDTH(4), .IN_HEIGHT(4)) ua (
    .clk(clk), .rst(rst), .i_data(a_d), .i_valid(a_v), .o_data(a_q), .o_valid(a_ov));
  maxpool_2x2 #(.DATA_WIDTH(16), .CHANNEL(8), .IN_WIDTH(8), .IN_HEIGHT(4)) ub (
    .clk(clk), .rst(rst), .i_data(b_d), .i_valid(b_v), .o_data(b_q), .o_valid(b_ov));
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // a_w/b_w mark beats at (odd row, odd col); a pooled pixel is due one cycle later.
  always @(posedge clk) begin
    a_wd <= a_v && a_w && !rst;
    b_wd <= b_v && b_w && !rst;
  end
  always @(negedge clk) begin
    if (a_ov) na++;
    if (b_ov) nb++;
    if (a_ov || a_wd) chk("a_valid", a_ov, a_wd);
    if (a_ov && a_wd && qa.size() > 0) chk("a_data", a_q, qa.pop_front());
    if (b_ov || b_wd) chk("b_valid", b_ov, b_wd);
    if (b_ov && b_wd && qb.size() > 0) chk("b_data", b_q, qb.pop_front());
  end
  task automatic run_a(input int maxgap, input int n);
    for (int i = 0; i < n; i++) begin
      a_d = fa[i];
      a_v = 1'b1;
      a_w = i[2] & i[0];
      @(posedge clk); #1;
      a_v = 1'b0;
      a_w = 1'b0;
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
    end
  endtask
  task automatic run_b(input int maxgap);
    for (int i = 0; i < 32; i++) begin
      b_d = fb[i];
      b_v = 1'b1;
      b_w = i[3] & i[0];
      @(posedge clk); #1;
      b_v = 1'b0;
      b_w = 1'b0;
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
    end
  endtask
  task automatic ramp_a();
    for (int i = 0; i < 16; i++) fa[i] = 16'(i);
    qa.push_back(128'd5); qa.push_back(128'd7); qa.push_back(128'd13); qa.push_back(128'd15);
  endtask
  // Channel ch peaks at quadrant position ch%4 of each block with value hi+k*16+ch.
  task automatic gen_b(input int hi, input int lo);
    logic [127:0] e;
    for (int i = 0; i < 32; i++) begin
      int r, cc, k, p;
      r = i >> 3; cc = i & 7;
      k = (r >> 1) * 4 + (cc >> 1);
      p = (r & 1) * 2 + (cc & 1);
      for (int ch = 0; ch < 8; ch++) fb[i][ch*16 +: 16] = 16'((p == ch % 4 ? hi : lo) + k * 16 + ch);
    end
    for (int k = 0; k < 8; k++) begin
      for (int ch = 0; ch < 8; ch++) e[ch*16 +: 16] = 16'(hi + k * 16 + ch);
      qb.push_back(e);
    end
  endtask
  task automatic rand_b();
    logic [127:0] e;
    logic signed [15:0] m, v;
    for (int i = 0; i < 32; i++) fb[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      for (int ch = 0; ch < 8; ch++) begin
        m = -16'sd32768;
        for (int q = 0; q < 4; q++) begin
          v = fb[((k >> 2) * 2 + (q >> 1)) * 8 + (k & 3) * 2 + (q & 1)][ch*16 +: 16];
          if (v > m) m = v;
        end
        e[ch*16 +: 16] = m;
      end
      qb.push_back(e);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ov", a_ov, 0);
    chk("rst_a_od", a_q, 0);
    chk("rst_b_ov", b_ov, 0);
    chk("rst_b_od", b_q, 0);
    rst = 1'b0;
    ramp_a();
    run_a(0, 16);
    fa = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'h0005,
           16'hFFF8, 16'hFFFE, 16'h0000, 16'hFFFF,
           16'h0001, 16'h8001, 16'h1234, 16'h1234,
           16'h7FFF, 16'hFFFF, 16'h1234, 16'h1234};
    qa.push_back(128'hFFFF); qa.push_back(128'h0005); qa.push_back(128'h7FFF); qa.push_back(128'h1234);
    run_a(0, 16);
    ramp_a();
    run_a(5, 16);
    gen_b(0, -500);
    run_b(0);
    gen_b(-1000, -2000);
    run_b(0);
    rand_b();
    run_b(5);
    rand_b();
    run_b(5);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) fa[i] = 16'h7000;
    run_a(0, 5);
    a_d = 16'h7FFF;
    a_v = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_v = 1'b0;
    chk("mid_rst_a_ov", a_ov, 0);
    chk("mid_rst_a_od", a_q, 0);
    chk("mid_rst_b_ov", b_ov, 0);
    chk("mid_rst_b_od", b_q, 0);
    ramp_a();
    run_a(2, 16);
    repeat (4) @(posedge clk);
    #1;
    chk("a_count", na, 16);
    chk("b_count", nb, 32);
    chk("a_left", qa.size(), 0);
    chk("b_left", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/maxpool_2x2.md
Name: maxpool_2x2

Overview:
- Downstream neighbour of the conv stage.
- Consumes the conv output pixel stream (raster order, one OUT_CHANNEL-wide pixel per valid beat) and produces a 2x2, stride-2 max-pooled stream in the same format.
- The output feeds the inter-layer FIFO of the next conv stage.
- No backpressure on either side: the upstream conv already throttles on fifo_almost_full.

Parameters:
- DATA_WIDTH, 16, bit width of one channel value; two's-complement fixed point. Format is irrelevant to max.
- CHANNEL, 8, number of channels per pixel; equals the upstream OUT_CHANNEL.
- IN_WIDTH, 512, input frame width in pixels; must be even.
- IN_HEIGHT, 256, input frame height in pixels; must be even.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- i_data  input  DATA_WIDTH*CHANNEL  input pixel; channel c at bits [(c+1)*DATA_WIDTH-1 : c*DATA_WIDTH]
- i_valid  input  1  i_data valid this cycle
- o_data  output  DATA_WIDTH*CHANNEL  pooled pixel; same channel packing as i_data
- o_valid  output  1  o_data valid, single-cycle pulse per pooled pixel

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset is synchronous and active-high (rst). It is sampled on the rising clk edge and overrides all other activity in that cycle.
  - Reset values: o_valid=0, o_data=0, col counter=0, row counter=0, phase=ROW_EVEN, horizontal register=0.
  - Row-buffer contents are not cleared; they are always written before being read.
- Counters:
  - col runs 0..IN_WIDTH-1 and row runs 0..IN_HEIGHT-1.
  - Both advance only on i_valid beats. Any number of idle cycles between beats is legal and has no effect.
  - col wraps to 0 after IN_WIDTH-1, and row then increments.
  - After (row=IN_HEIGHT-1, col=IN_WIDTH-1), both wrap to 0, so back-to-back frames need no gap.
- Per-channel compare: signed DATA_WIDTH comparison. Ties select either operand; the result is identical.
- Horizontal stage (every row):
  - On an even-col beat, latch the pixel into register h.
  - On an odd-col beat, hmax = per-channel max(h, i_data).
- Phase FSM, two states, transition on the accepted beat with col=IN_WIDTH-1:
  - ROW_EVEN: on each odd-col beat, write hmax to row_buf[col>>1]. No output. Next state ROW_ODD.
  - ROW_ODD: on each odd-col beat, o_data <= per-channel max(row_buf[col>>1], hmax) and o_valid <= 1 for one cycle. Next state ROW_EVEN.
- row_buf:
  - IN_WIDTH/2 entries of DATA_WIDTH*CHANNEL bits.
  - Must infer as simple dual-port RAM with registered read.
  - Read address (col>>1) is presented on the even-col beat of ROW_ODD. Read data is held until the matching odd-col beat, regardless of i_valid gaps.
- Latency: o_valid asserts exactly 1 cycle after the i_valid beat at (odd row, odd col).
- Throughput: at most one output per 2 input beats. Exactly (IN_WIDTH/2)*(IN_HEIGHT/2) outputs per frame.
- Output idle value: o_valid=0 on every cycle without a new result. o_data holds its last value and is don't-care when o_valid=0.
- Reset mid-frame: the partial frame is discarded and no further outputs come from it. The next i_valid beat after rst deasserts is treated as (row 0, col 0).
- rst and i_valid asserted in the same cycle: the beat is dropped.
- Arithmetic: no width growth, no saturation, no rounding; outputs are bit-exact copies of input values.

Test Plan:
- 4x4 frame, CHANNEL=1, values 0..15 in raster order, i_valid continuous -> exactly 4 outputs: 5, 7, 13, 15. Each o_valid arrives 1 cycle after the input beats at (1,1), (1,3), (3,1), (3,3).
- Negative values: 2x2 block {-3, -1, -8, -2}, i.e. 16'hFFFD, FFFF, FFF8, FFFE -> output 16'hFFFF. Block {-32768, 5, 0, -1} -> output 5.
- CHANNEL=8 with each channel's maximum at a different quadrant position -> every channel independently yields its own maximum; no cross-channel mixing.
- Random 0-5 cycle i_valid gaps, including gaps between the even-col read and the odd-col beat, on a 512x256 frame -> results match the golden model bit-exactly and the output count is 32768.
- Two back-to-back 8x4 frames with no gap -> 8 outputs per frame, and frame 2's results are unaffected by frame 1's row_buf contents.
- rst pulsed mid-way through row 1 of a 4x4 frame, then a fresh frame -> no output from the partial frame, o_valid=0 and o_data=0 the cycle after rst, and the fresh frame produces its 4 correct outputs.
